// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, register-file write ports,
// processor status state machine and retired/cycle counters.
module writeback (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        writeback_stall_i,
    input  logic        writeback_bubble_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [63:0] M_valE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [63:0] m_valM_i,
    output logic [3:0]  W_icode_o,
    output logic [2:0]  W_stat_o,
    output logic [3:0]  W_dstE_o,
    output logic [63:0] W_valE_o,
    output logic [3:0]  W_dstM_o,
    output logic [63:0] W_valM_o,
    output logic [2:0]  stat_o,
    output logic        halted_o,
    output logic [63:0] retired_cnt_o,
    output logic [63:0] cycle_cnt_o
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [2:0] SADR  = 3'd2;
    localparam logic [2:0] SINS  = 3'd3;
    localparam logic [2:0] SHLT  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [3:0]  w_icode_reg;
    logic [2:0]  w_stat_reg;
    logic [3:0]  w_dste_reg;
    logic [63:0] w_vale_reg;
    logic [3:0]  w_dstm_reg;
    logic [63:0] w_valm_reg;
    logic        w_valid_reg;
    logic [63:0] retired_cnt_reg;
    logic [63:0] cycle_cnt_reg;

    logic        load_en;
    logic        load_m;

    // The register only moves while running; stall wins over bubble.
    assign load_en = (state_reg == ST_RUN) && !writeback_stall_i;
    assign load_m  = load_en && !writeback_bubble_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_icode_reg <= INOP;
            w_stat_reg  <= SAOK;
            w_dste_reg  <= RNONE;
            w_vale_reg  <= '0;
            w_dstm_reg  <= RNONE;
            w_valm_reg  <= '0;
            w_valid_reg <= 1'b0;
        end else if (load_en) begin
            if (writeback_bubble_i) begin
                w_icode_reg <= INOP;
                w_stat_reg  <= SAOK;
                w_dste_reg  <= RNONE;
                w_vale_reg  <= '0;
                w_dstm_reg  <= RNONE;
                w_valm_reg  <= '0;
                w_valid_reg <= 1'b0;
            end else begin
                w_icode_reg <= M_icode_i;
                w_stat_reg  <= M_stat_i;
                w_dste_reg  <= M_dstE_i;
                w_vale_reg  <= M_valE_i;
                w_dstm_reg  <= M_dstM_i;
                w_valm_reg  <= m_valM_i;
                w_valid_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_cnt_reg <= '0;
            cycle_cnt_reg   <= '0;
        end else begin
            if (state_reg == ST_RUN) begin
                cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
            end
            if (load_m && (M_stat_i == SAOK)) begin
                retired_cnt_reg <= retired_cnt_reg + 64'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Any stat other than AOK or HLT (including undefined codes) is a fault.
    always_comb begin
        state_next = state_reg;
        if (load_m) begin
            if (M_stat_i == SHLT) begin
                state_next = ST_HALT;
            end else if (M_stat_i != SAOK) begin
                state_next = ST_FAULT;
            end
        end
    end

    // The W register freezes on the faulting instruction, so its stat
    // tells an address fault apart from everything else.
    always_comb begin
        halted_o = (state_reg != ST_RUN);
        case (state_reg)
            ST_RUN:   stat_o = SAOK;
            ST_HALT:  stat_o = SHLT;
            ST_FAULT: stat_o = (w_stat_reg == SADR) ? SADR : SINS;
            default:  stat_o = SINS;
        endcase
    end

    assign W_icode_o     = w_icode_reg;
    assign W_stat_o      = w_stat_reg;
    assign W_dstE_o      = (w_valid_reg && (w_stat_reg == SAOK)) ? w_dste_reg : RNONE;
    assign W_dstM_o      = (w_valid_reg && (w_stat_reg == SAOK)) ? w_dstm_reg : RNONE;
    assign W_valE_o      = w_vale_reg;
    assign W_valM_o      = w_valm_reg;
    assign retired_cnt_o = retired_cnt_reg;
    assign cycle_cnt_o   = cycle_cnt_reg;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: a behavioural model checked every cycle,
// plus hand-computed expectations at each step of the scenario.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        bubble = 1'b0;
    logic [2:0]  m_stat = 3'd1;
    logic [3:0]  m_icode = 4'h1;
    logic [3:0]  m_dste = 4'hF;
    logic [63:0] m_vale = '0;
    logic [3:0]  m_dstm = 4'hF;
    logic [63:0] m_valm = '0;

    logic [3:0]  w_icode;
    logic [2:0]  w_stat;
    logic [3:0]  w_dste;
    logic [63:0] w_vale;
    logic [3:0]  w_dstm;
    logic [63:0] w_valm;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired_cnt;
    logic [63:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    writeback dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .writeback_stall_i  (stall),
        .writeback_bubble_i (bubble),
        .M_stat_i           (m_stat),
        .M_icode_i          (m_icode),
        .M_dstE_i           (m_dste),
        .M_valE_i           (m_vale),
        .M_dstM_i           (m_dstm),
        .m_valM_i           (m_valm),
        .W_icode_o          (w_icode),
        .W_stat_o           (w_stat),
        .W_dstE_o           (w_dste),
        .W_valE_o           (w_vale),
        .W_dstM_o           (w_dstm),
        .W_valM_o           (w_valm),
        .stat_o             (stat),
        .halted_o           (halted),
        .retired_cnt_o      (retired_cnt),
        .cycle_cnt_o        (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the processor status is AOK until an exceptional instruction is
    // accepted, after which nothing is accepted and nothing is counted.
    logic [3:0]  md_icode;
    logic [2:0]  md_stat;
    logic [3:0]  md_dste;
    logic [63:0] md_vale;
    logic [3:0]  md_dstm;
    logic [63:0] md_valm;
    logic [2:0]  md_status;
    logic [63:0] md_ret;
    logic [63:0] md_cyc;

    function automatic logic [2:0] classify(input logic [2:0] s);
        if (s == 3'd4) return 3'd4;
        if (s == 3'd2) return 3'd2;
        return 3'd3;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_icode = 4'h1; md_stat = 3'd1;
            md_dste = 4'hF; md_vale = '0; md_dstm = 4'hF; md_valm = '0;
            md_status = 3'd1; md_ret = '0; md_cyc = '0;
        end else if (md_status == 3'd1) begin
            md_cyc = md_cyc + 1;
            if (!stall && bubble) begin
                md_icode = 4'h1; md_stat = 3'd1;
                md_dste = 4'hF; md_vale = '0; md_dstm = 4'hF; md_valm = '0;
            end else if (!stall) begin
                md_icode = m_icode; md_stat = m_stat;
                md_dste = m_dste; md_vale = m_vale; md_dstm = m_dstm; md_valm = m_valm;
                if (m_stat == 3'd1) md_ret = md_ret + 1;
                else md_status = classify(m_stat);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_icode", {60'd0, w_icode}, {60'd0, md_icode});
            chk("cmp_wstat", {61'd0, w_stat}, {61'd0, md_stat});
            chk("cmp_dstE", {60'd0, w_dste}, {60'd0, (md_stat == 3'd1) ? md_dste : 4'hF});
            chk("cmp_valE", w_vale, md_vale);
            chk("cmp_dstM", {60'd0, w_dstm}, {60'd0, (md_stat == 3'd1) ? md_dstm : 4'hF});
            chk("cmp_valM", w_valm, md_valm);
            chk("cmp_stat", {61'd0, stat}, {61'd0, md_status});
            chk("cmp_halted", {63'd0, halted}, {63'd0, md_status != 3'd1});
            chk("cmp_retired", retired_cnt, md_ret);
            chk("cmp_cycle", cycle_cnt, md_cyc);
        end
    end

    task automatic step(input logic st, input logic bu, input logic [2:0] s, input logic [3:0] ic,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        stall = st; bubble = bu; m_stat = s; m_icode = ic;
        m_dste = de; m_vale = ve; m_dstm = dm; m_valm = vm;
        @(posedge clk);
        #1;
        $display("step stall=%0d bubble=%0d stat=%0d -> W_icode=%0h dstE=%0h dstM=%0h stat_o=%0d ret=%0d cyc=%0d",
                 st, bu, s, w_icode, w_dste, w_dstm, stat, retired_cnt, cycle_cnt);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_icode"}, {60'd0, w_icode}, 64'h1);
        chk({tag, "_wstat"}, {61'd0, w_stat}, 64'd1);
        chk({tag, "_dstE"}, {60'd0, w_dste}, 64'hF);
        chk({tag, "_dstM"}, {60'd0, w_dstm}, 64'hF);
        chk({tag, "_valE"}, w_vale, 64'd0);
        chk({tag, "_valM"}, w_valm, 64'd0);
        chk({tag, "_stat"}, {61'd0, stat}, 64'd1);
        chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
        chk({tag, "_retired"}, retired_cnt, 64'd0);
        chk({tag, "_cycle"}, cycle_cnt, 64'd0);
    endtask

    // Reset pulsed between edges must take effect immediately.
    task automatic reset_pulse(input string tag);
        #1 rst = 1'b1;
        #1;
        check_reset_values(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        step(0, 0, 3'd1, 4'h6, 4'h3, 64'h10, 4'hF, 64'h0);
        chk("load_dstE", {60'd0, w_dste}, 64'h3);
        chk("load_valE", w_vale, 64'h10);
        chk("load_dstM", {60'd0, w_dstm}, 64'hF);
        chk("load_retired", retired_cnt, 64'd1);

        for (int i = 0; i < 3; i++)
            step(1, 0, 3'd1, 4'h2, 4'(i), 64'hA0 + 64'(i), 4'h7, 64'hBEEF);
        chk("stall_icode", {60'd0, w_icode}, 64'h6);
        chk("stall_valE", w_vale, 64'h10);
        chk("stall_retired", retired_cnt, 64'd1);
        chk("stall_cycle", cycle_cnt, 64'd4);

        step(0, 1, 3'd1, 4'h2, 4'h8, 64'h99, 4'h9, 64'h77);
        chk("bubble_icode", {60'd0, w_icode}, 64'h1);
        chk("bubble_dstE", {60'd0, w_dste}, 64'hF);
        chk("bubble_dstM", {60'd0, w_dstm}, 64'hF);
        chk("bubble_retired", retired_cnt, 64'd1);

        step(1, 1, 3'd1, 4'h3, 4'h2, 64'h55, 4'h4, 64'h66);
        chk("stallbub_icode", {60'd0, w_icode}, 64'h1);
        chk("stallbub_valE", w_vale, 64'h0);
        chk("stallbub_cycle", cycle_cnt, 64'd6);

        step(0, 0, 3'd1, 4'h5, 4'h5, 64'h1, 4'h5, 64'h2);
        chk("dual_dstE", {60'd0, w_dste}, 64'h5);
        chk("dual_dstM", {60'd0, w_dstm}, 64'h5);
        chk("dual_valE", w_vale, 64'h1);
        chk("dual_valM", w_valm, 64'h2);
        chk("dual_retired", retired_cnt, 64'd2);

        step(0, 0, 3'd4, 4'h0, 4'h4, 64'h44, 4'hF, 64'h0);
        chk("halt_dstE", {60'd0, w_dste}, 64'hF);
        chk("halt_stat", {61'd0, stat}, 64'd4);
        chk("halt_halted", {63'd0, halted}, 64'd1);
        chk("halt_cycle", cycle_cnt, 64'd8);
        chk("halt_retired", retired_cnt, 64'd2);

        for (int i = 0; i < 5; i++)
            step(0, 0, 3'd1, 4'h6, 4'h1, 64'h1234 + 64'(i), 4'h2, 64'h5678);
        chk("frozen_icode", {60'd0, w_icode}, 64'h0);
        chk("frozen_valE", w_vale, 64'h44);
        chk("frozen_cycle", cycle_cnt, 64'd8);
        chk("frozen_retired", retired_cnt, 64'd2);

        reset_pulse("areset_halt");
        step(0, 0, 3'd1, 4'h6, 4'h7, 64'h55, 4'hF, 64'h0);
        chk("post_reset_dstE", {60'd0, w_dste}, 64'h7);
        chk("post_reset_retired", retired_cnt, 64'd1);
        chk("post_reset_cycle", cycle_cnt, 64'd1);

        step(0, 0, 3'd2, 4'h5, 4'hF, 64'h0, 4'h2, 64'hDEAD);
        chk("adr_dstM", {60'd0, w_dstm}, 64'hF);
        chk("adr_stat", {61'd0, stat}, 64'd2);
        chk("adr_halted", {63'd0, halted}, 64'd1);
        chk("adr_retired", retired_cnt, 64'd1);
        step(0, 0, 3'd1, 4'h6, 4'h3, 64'h1, 4'hF, 64'h0);
        chk("adr_sticky_stat", {61'd0, stat}, 64'd2);

        reset_pulse("areset_fault");
        step(0, 0, 3'd6, 4'h6, 4'h3, 64'h1, 4'hF, 64'h0);
        chk("bad_stat", {61'd0, stat}, 64'd3);
        chk("bad_halted", {63'd0, halted}, 64'd1);
        chk("bad_retired", retired_cnt, 64'd0);
        chk("bad_cycle", cycle_cnt, 64'd1);
        step(0, 0, 3'd1, 4'h6, 4'h3, 64'h1, 4'hF, 64'h0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
